symbol_packer: RTL and testbench
================================

SYMBOL_PACKER -- requirements
Module: symbol_packer

Interface
REQ-001 SHALL have parameter BITS_WIDTH, default 5, giving the symbol width in bits (32-point constellation: 2+2+1 dimension bits).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, giving the overflow counter width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 bit_in  input  1  serial payload bit.
REQ-006 bit_valid  input  1  bit_in is valid this cycle; no back-pressure on the serial side.
REQ-007 sync  input  1  frame-alignment strobe; discards any partial symbol.
REQ-008 data  output  BITS_WIDTH  packed symbol to the encoder stage.
REQ-009 data_valid  output  1  data holds an unconsumed symbol.
REQ-010 data_ready  input  1  downstream accepts data this cycle.
REQ-011 ovf  output  1  one-cycle pulse: completed symbol dropped.
REQ-012 ovf_cnt  output  CNT_WIDTH  saturating count of dropped symbols.

Function
REQ-013 SHALL accumulate bits LSB-first: the first accepted bit after reset or sync goes to data[0], the BITS_WIDTH-th to data[BITS_WIDTH-1].
REQ-014 SHALL keep a bit counter 0..BITS_WIDTH-1, incremented on each accepted bit and wrapping to 0 when the symbol completes.
REQ-015 SHALL have a two-state output buffer: EMPTY (data_valid=0) and FULL (data_valid=1).
REQ-016 SHALL transfer a symbol to downstream only on a cycle with data_valid=1 and data_ready=1; data SHALL stay stable while data_valid=1 and data_ready=0.
REQ-017 Latency: bit completing a symbol accepted at edge N -> data/data_valid updated at edge N (visible the cycle after bit_valid was sampled); no combinational path from bit_in or data_ready to any output.
REQ-018 On completion with buffer EMPTY: load the symbol, go to FULL.
REQ-019 On completion with buffer FULL and data_ready=1 in the same cycle: load the new symbol, stay FULL (no bubble, no drop).
REQ-020 On completion with buffer FULL and data_ready=0: drop the new symbol, keep the old data, pulse ovf for one cycle, increment ovf_cnt.
REQ-021 FULL with data_ready=1 and no completion: go to EMPTY; data SHALL keep its last value.
REQ-022 sync=1: clear the bit counter and the partial shift contents; do not affect the output buffer. If bit_valid=1 in the same cycle, that bit SHALL be taken as bit 0 of the new symbol.
REQ-023 bit_valid=0: hold the bit counter and partial symbol indefinitely.
REQ-024 ovf_cnt SHALL saturate at all-ones and never wrap.

Reset
REQ-025 While rst=1: data=0, data_valid=0, ovf=0, ovf_cnt=0, bit counter=0, partial symbol=0, buffer EMPTY.
REQ-026 Assertion mid-symbol or with buffer FULL SHALL discard all held bits and symbols immediately, without waiting for a clock edge.
REQ-027 The first bit accepted after rst deasserts SHALL be data[0] of the first symbol.

Configuration
REQ-028 Macro SYMBOL_PACKER_OVF_CNT_EN: when defined, ovf_cnt behaves per REQ-020/REQ-024.
REQ-029 When SYMBOL_PACKER_OVF_CNT_EN is undefined, ovf_cnt SHALL be tied to 0 and no counter logic SHALL be built; ovf SHALL be unaffected.

Verification
REQ-030 Reset, then 5 bits 1,0,1,1,0 with bit_valid=1 and data_ready=1 -> data=5'b01101, data_valid=1 for exactly one cycle.
REQ-031 data_ready=0, 10 consecutive bits -> first symbol held stable, second dropped, ovf one-cycle pulse, ovf_cnt=1 (0 without the macro).
REQ-032 3 bits, then sync with bit_valid=1 and bit=1, then 4 bits 0 -> data=5'b00001; the partial bits are not emitted.
REQ-033 Back-to-back symbols with data_ready=1 on each completion cycle -> data_valid stays 1 across the boundary, zero drops.
REQ-034 rst asserted asynchronously after 2 bits with buffer FULL -> all outputs 0 before the next edge; a following 5-bit sequence packs from data[0].
REQ-035 Force 2^CNT_WIDTH+3 overflows -> ovf_cnt holds 255 (CNT_WIDTH=8), no wrap.

Source files
------------

// File: rtl/symbol_packer_if.sv
// Serial-bit and packed-symbol bus of the symbol packer.
// slave: packer side; master: bit source / downstream consumer side.
interface symbol_packer_if #(
  parameter int BITS_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
);
  logic                  bit_in;
  logic                  bit_valid;
  logic                  sync;
  logic [BITS_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  data_ready;
  logic                  ovf;
  logic [CNT_WIDTH-1:0]  ovf_cnt;

  modport slave (
    input  bit_in, bit_valid, sync, data_ready,
    output data, data_valid, ovf, ovf_cnt
  );

  modport master (
    output bit_in, bit_valid, sync, data_ready,
    input  data, data_valid, ovf, ovf_cnt
  );
endinterface

// File: rtl/symbol_packer.sv
// Packs serial bits LSB-first into BITS_WIDTH-bit symbols behind a one-entry output buffer.
// Optional macro SYMBOL_PACKER_OVF_CNT_EN builds the saturating dropped-symbol counter.
module symbol_packer #(
  parameter int BITS_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
) (
  input  logic            clk,
  input  logic            rst,
  symbol_packer_if.slave  bus
);

  localparam int CW = (BITS_WIDTH > 1) ? $clog2(BITS_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BITS_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [CW-1:0]         bit_cnt_r;
  logic [BITS_WIDTH-1:0] shift_r;
  logic [BITS_WIDTH-1:0] data_r;
  logic                  ovf_r;

  logic [CW-1:0]         eff_cnt_s;
  logic [BITS_WIDTH-1:0] eff_shift_s;
  logic [BITS_WIDTH-1:0] new_sym_s;
  logic                  complete_s;
  logic                  load_s;
  logic                  drop_s;

  // Sync restarts the symbol, so a bit accepted alongside it lands at position 0.
  always_comb begin
    eff_cnt_s   = sync_sel_cnt(bus.sync, bit_cnt_r);
    eff_shift_s = bus.sync ? {BITS_WIDTH{1'b0}} : shift_r;
    new_sym_s   = eff_shift_s;
    for (int i = 0; i < BITS_WIDTH; i++) begin
      if (eff_cnt_s == CW'(i)) begin
        new_sym_s[i] = bus.bit_in;
      end else begin
        new_sym_s[i] = eff_shift_s[i];
      end
    end
    complete_s = bus.bit_valid && (eff_cnt_s == LAST_CNT);
  end

  function automatic logic [CW-1:0] sync_sel_cnt(input logic s, input logic [CW-1:0] c);
    return s ? {CW{1'b0}} : c;
  endfunction

  // Buffer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Buffer next-state: a completion always leaves the buffer FULL.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (complete_s) state_next_s = ST_FULL;
        else            state_next_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (!complete_s && bus.data_ready) state_next_s = ST_EMPTY;
        else                               state_next_s = ST_FULL;
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // Buffer outputs: load when room exists (or is being freed), else drop.
  always_comb begin
    load_s = 1'b0;
    drop_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        load_s = complete_s;
        drop_s = 1'b0;
      end
      ST_FULL: begin
        if (complete_s) begin
          load_s = bus.data_ready;
          drop_s = !bus.data_ready;
        end else begin
          load_s = 1'b0;
          drop_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
        drop_s = 1'b0;
      end
    endcase
  end

  // Bit counter and partial-symbol shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r <= {CW{1'b0}};
      shift_r   <= {BITS_WIDTH{1'b0}};
    end else if (complete_s) begin
      bit_cnt_r <= {CW{1'b0}};
      shift_r   <= {BITS_WIDTH{1'b0}};
    end else if (bus.bit_valid) begin
      bit_cnt_r <= eff_cnt_s + CW'(1);
      shift_r   <= new_sym_s;
    end else if (bus.sync) begin
      bit_cnt_r <= {CW{1'b0}};
      shift_r   <= {BITS_WIDTH{1'b0}};
    end else begin
      bit_cnt_r <= bit_cnt_r;
      shift_r   <= shift_r;
    end
  end

  // Output data register and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= {BITS_WIDTH{1'b0}};
      ovf_r  <= 1'b0;
    end else begin
      data_r <= load_s ? new_sym_s : data_r;
      ovf_r  <= drop_s;
    end
  end

`ifdef SYMBOL_PACKER_OVF_CNT_EN
  logic [CNT_WIDTH-1:0] ovf_cnt_r;

  // Saturating count of dropped symbols.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (drop_s && (ovf_cnt_r != {CNT_WIDTH{1'b1}})) begin
      ovf_cnt_r <= ovf_cnt_r + CNT_WIDTH'(1);
    end else begin
      ovf_cnt_r <= ovf_cnt_r;
    end
  end

  assign bus.ovf_cnt = ovf_cnt_r;
`else
  assign bus.ovf_cnt = {CNT_WIDTH{1'b0}};
`endif

  assign bus.data       = data_r;
  assign bus.data_valid = (state_r == ST_FULL);
  assign bus.ovf        = ovf_r;

endmodule

// File: tb/tb_symbol_packer.sv
// Directed self-checking bench for symbol_packer (BITS_WIDTH=5, CNT_WIDTH=8).
module tb_symbol_packer;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_cnt;
  int   pulses;

  symbol_packer_if #(.BITS_WIDTH(5), .CNT_WIDTH(8)) bus ();

  symbol_packer #(.BITS_WIDTH(5), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic step(input logic b, input logic v, input logic s, input logic rdy);
    bus.bit_in     = b;
    bus.bit_valid  = v;
    bus.sync       = s;
    bus.data_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send5(input logic [4:0] sym, input logic rdy);
    for (int i = 0; i < 5; i++) step(sym[i], 1'b1, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int cnt_exp(input int n);
`ifdef SYMBOL_PACKER_OVF_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0 * n;
`endif
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.sync = 1'b0; bus.data_ready = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_cnt", 32'(bus.ovf_cnt), 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Basic pack: bits 1,0,1,1,0 -> 5'b01101, valid for one cycle.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t1_valid_pre", 32'(bus.data_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("t1_data", 32'(bus.data), 32'b01101);
    check("t1_valid", 32'(bus.data_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_valid_drop", 32'(bus.data_valid), 32'd0);
    check("t1_data_hold", 32'(bus.data), 32'b01101);

    // Overflow: ready low, 10 bits -> first held, second dropped.
    send5(5'b10011, 1'b0);
    check("t2_data1", 32'(bus.data), 32'b10011);
    check("t2_ovf_pre", 32'(bus.ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(i[0], 1'b1, 1'b0, 1'b0);
      check("t2_stable", 32'(bus.data), 32'b10011);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_ovf", 32'(bus.ovf), 32'd1);
    check("t2_cnt", 32'(bus.ovf_cnt), 32'(cnt_exp(1)));
    check("t2_keep", 32'(bus.data), 32'b10011);
    check("t2_valid", 32'(bus.data_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_ovf_pulse", 32'(bus.ovf), 32'd0);
    check("t2_cnt_hold", 32'(bus.ovf_cnt), 32'(cnt_exp(1)));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_drain", 32'(bus.data_valid), 32'd0);

    // Sync with a bit in the same cycle starts a fresh symbol.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("t3_no_partial", 32'(bus.data_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("t3_data", 32'(bus.data), 32'b00001);
    check("t3_valid", 32'(bus.data_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: consume on completion cycle, no bubble or drop.
    send5(5'b11110, 1'b0);
    check("t4_a", 32'(bus.data), 32'b11110);
    for (int i = 0; i < 4; i++) step((i == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_a_hold", 32'(bus.data_valid), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t4_b", 32'(bus.data), 32'b10001);
    check("t4_b_valid", 32'(bus.data_valid), 32'd1);
    check("t4_no_ovf", 32'(bus.ovf), 32'd0);
    check("t4_cnt", 32'(bus.ovf_cnt), 32'(cnt_exp(1)));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_drain", 32'(bus.data_valid), 32'd0);

    // Async reset mid-symbol with buffer FULL.
    send5(5'b00001, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    bus.bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_async_data", 32'(bus.data), 32'd0);
    check("t5_async_valid", 32'(bus.data_valid), 32'd0);
    check("t5_async_cnt", 32'(bus.ovf_cnt), 32'd0);
    #1 rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send5(5'b11010, 1'b1);
    check("t5_repack", 32'(bus.data), 32'b11010);
    check("t5_valid", 32'(bus.data_valid), 32'd1);

    // Saturation: 2^8+3 drops.
    do_reset();
    send5(5'b10101, 1'b0);
    pulses = 0;
    for (int n = 0; n < 259; n++) begin
      for (int i = 0; i < 5; i++) begin
        step(1'b0, 1'b1, 1'b0, 1'b0);
        if (bus.ovf) pulses++;
      end
      if (n == 254) check("t6_cnt_255", 32'(bus.ovf_cnt), 32'(cnt_exp(255)));
    end
    check("t6_pulses", 32'(pulses), 32'd259);
    check("t6_sat", 32'(bus.ovf_cnt), 32'(cnt_exp(259)));
    check("t6_keep", 32'(bus.data), 32'b10101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
